// File: rtl/meta_info_pkg.sv
// Shared types and constants for the meta-info ROM string reader.
package meta_info_pkg;

    localparam int IDX_W = 6;
    localparam int CHR_W = 8;
    localparam int CNT_W = 4;

    localparam logic [CHR_W-1:0] NUL = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPT,
        EMIT,
        FIN
    } reader_state_t;

endpackage

// File: rtl/meta_info_reader_if.sv
// Pin-level bundle between the reader, the meta-info ROM and the byte consumer.
interface meta_info_reader_if #(
    parameter int IDX_W = meta_info_pkg::IDX_W
);
    import meta_info_pkg::*;

    logic                 start_i;
    logic [IDX_W-1:0]     proj_sel_i;
    logic                 busy_o;
    logic [IDX_W-1:0]     proj_idx_o;
    logic [IDX_W-1:0]     chr_idx_o;
    logic [CHR_W-1:0]     chr_i;
    logic [CHR_W-1:0]     byte_o;
    logic                 byte_valid_o;
    logic                 byte_ready_i;
    logic                 done_o;
    logic [IDX_W:0]       len_o;

    modport master (
        input  start_i, proj_sel_i, chr_i, byte_ready_i,
        output busy_o, proj_idx_o, chr_idx_o, byte_o, byte_valid_o, done_o, len_o
    );

    modport slave (
        output start_i, proj_sel_i, chr_i, byte_ready_i,
        input  busy_o, proj_idx_o, chr_idx_o, byte_o, byte_valid_o, done_o, len_o
    );

endinterface

// File: rtl/meta_info_settle_timer.sv
// Loadable down-counter that measures how long a ROM address has been held.
module meta_info_settle_timer
    import meta_info_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/meta_info_reader.sv
// Walks one project's NUL-terminated string in the meta-info ROM and streams it
// out byte by byte over valid/ready, reporting the string length when done.
module meta_info_reader
    import meta_info_pkg::*;
#(
    parameter int SETTLE  = 3,
    parameter int MAX_LEN = 63
) (
    input  logic               clock,
    input  logic               reset,
    meta_info_reader_if.master bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(MAX_LEN - 1);
    localparam logic [IDX_W:0]   MAX_LEN_V   = (IDX_W + 1)'(MAX_LEN);

    reader_state_t      state_q, state_d;
    logic [IDX_W-1:0]   proj_idx_q, proj_idx_d;
    logic [IDX_W-1:0]   chr_idx_q, chr_idx_d;
    logic [CHR_W-1:0]   byte_q, byte_d;
    logic               byte_valid_q, byte_valid_d;
    logic [IDX_W:0]     len_q, len_d;

    logic               timer_load;
    logic               timer_expired;

    meta_info_settle_timer u_settle (
        .clock     (clock),
        .reset     (reset),
        .load_i    (timer_load),
        .en_i      (state_q == WAIT),
        .value_i   (SETTLE_LOAD),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        proj_idx_d   = proj_idx_q;
        chr_idx_d    = chr_idx_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;
        len_d        = len_q;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    proj_idx_d = bus.proj_sel_i;
                    chr_idx_d  = '0;
                    timer_load = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (timer_expired) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (bus.chr_i == NUL) begin
                    len_d   = {1'b0, chr_idx_q};
                    state_d = FIN;
                end else begin
                    byte_d       = bus.chr_i;
                    byte_valid_d = 1'b1;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                if (byte_valid_q && bus.byte_ready_i) begin
                    byte_valid_d = 1'b0;
                    // Stop on the last legal index so chr_idx never wraps.
                    if (chr_idx_q == LAST_IDX) begin
                        len_d   = MAX_LEN_V;
                        state_d = FIN;
                    end else begin
                        chr_idx_d  = chr_idx_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = WAIT;
                    end
                end
            end
            FIN: begin
                chr_idx_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            proj_idx_q   <= '0;
            chr_idx_q    <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            proj_idx_q   <= proj_idx_d;
            chr_idx_q    <= chr_idx_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            len_q        <= len_d;
        end
    end

    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == FIN);
    assign bus.proj_idx_o   = proj_idx_q;
    assign bus.chr_idx_o    = chr_idx_q;
    assign bus.byte_o       = byte_q;
    assign bus.byte_valid_o = byte_valid_q;
    assign bus.len_o        = len_q;

endmodule
